// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencing controller.
//   - ALU select codes driven on alu_s
//   - FSM state encoding of the sequencer
//   - command record layout stored in the command queue (19 bits)
package alu_seq_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_NOTB = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_OR   = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int CMD_W = 19;

    typedef struct packed {
        logic [1:0] op;
        logic       src;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Bus bundle of the ALU sequencing controller.
//   command side : cmd_valid/cmd_ready, cmd_op, cmd_src, cmd_a, cmd_b
//   ALU side     : alu_a, alu_b, alu_s out; alu_f, alu_ovf back
//   result side  : res_valid/res_ready, res_data, res_ovf
//   status       : acc, ovf_sticky, ovf_clr
// slave  = the controller, master = whoever drives commands and hosts the ALU.
interface alu_seq_ctrl_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_src;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_s;
    logic [7:0] alu_f;
    logic       alu_ovf;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_ovf;
    logic [7:0] acc;
    logic       ovf_sticky;
    logic       ovf_clr;

    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_a, cmd_b,
        input  alu_f, alu_ovf, res_ready, ovf_clr,
        output cmd_ready, alu_a, alu_b, alu_s,
        output res_valid, res_data, res_ovf, acc, ovf_sticky
    );

    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_a, cmd_b,
        output alu_f, alu_ovf, res_ready, ovf_clr,
        input  cmd_ready, alu_a, alu_b, alu_s,
        input  res_valid, res_data, res_ovf, acc, ovf_sticky
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command queue, DEPTH entries of cmd_t (power of two, min 2).
//   clk, rst  : clock, synchronous active-high reset (empties the queue)
//   i_push    : write i_data (ignored when full)
//   i_pop     : drop the head entry (ignored when empty)
//   o_data    : head entry
//   o_full, o_empty, o_count : occupancy, count range 0..DEPTH
module alu_cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  cmd_t                     i_data,
    input  logic                     i_pop,
    output cmd_t                     o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    cmd_t            r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer that feeds queued commands one at a time to an external 8-bit ALU
// and holds each result until it is consumed.
//   clk, rst : clock, synchronous active-high reset
//   bus      : alu_seq_ctrl_if.slave (command, ALU, result and status signals)
//
// state | meaning
// IDLE  | waiting for a queued command; pops head and registers ALU operands
// EXEC  | ALU operands stable; result sampled on the edge leaving EXEC
// RESP  | result held on res_data/res_ovf until res_ready
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    alu_seq_ctrl_if.slave  bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    cmd_t            w_push_cmd;
    cmd_t            w_head;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    logic            w_pop;
    logic            w_capture_ovf;

    logic [1:0]      r_state;
    logic [7:0]      r_alu_a;
    logic [7:0]      r_alu_b;
    logic [1:0]      r_alu_s;
    logic [7:0]      r_res_data;
    logic            r_res_ovf;
    logic [7:0]      r_acc;
    logic            r_ovf_sticky;

    assign w_push_cmd = '{op: bus.cmd_op, src: bus.cmd_src, a: bus.cmd_a, b: bus.cmd_b};
    assign w_pop      = (r_state == ST_IDLE) && !w_empty;

    alu_cmd_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (bus.cmd_valid),
        .i_data  (w_push_cmd),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Count is registered, so a pop while full only frees a slot next cycle.
    assign bus.cmd_ready = !w_full && (w_count < CW'(FIFO_DEPTH));

    // Overflow only means something for the add select.
    assign w_capture_ovf = (r_state == ST_EXEC) && (r_alu_s == OP_ADD) && bus.alu_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_s      <= OP_ADD;
            r_res_data   <= '0;
            r_res_ovf    <= 1'b0;
            r_acc        <= '0;
            r_ovf_sticky <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_alu_a <= w_head.src ? w_head.a : r_acc;
                        r_alu_b <= w_head.b;
                        r_alu_s <= w_head.op;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_res_data <= bus.alu_f;
                    r_acc      <= bus.alu_f;
                    r_res_ovf  <= w_capture_ovf;
                    r_state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.res_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            // Set wins over a same-edge clear.
            if (w_capture_ovf)    r_ovf_sticky <= 1'b1;
            else if (bus.ovf_clr) r_ovf_sticky <= 1'b0;
        end
    end

    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_s      = r_alu_s;
    assign bus.res_valid  = (r_state == ST_RESP);
    assign bus.res_data   = r_res_data;
    assign bus.res_ovf    = r_res_ovf;
    assign bus.acc        = r_acc;
    assign bus.ovf_sticky = r_ovf_sticky;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed cases plus random traffic
// checked against an in-order reference model of the command stream.
module tb_alu_seq_ctrl;

    typedef struct packed {
        logic [1:0] op;
        logic       src;
        logic [7:0] a;
        logic [7:0] b;
    } tcmd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_seq_ctrl_if bus();

    alu_seq_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // External ALU; overflow is reported for every select so the controller's
    // add-only gating is exercised.
    logic [7:0] alu_sum;
    always_comb begin
        alu_sum = bus.alu_a + bus.alu_b;
        case (bus.alu_s)
            2'b00:   bus.alu_f = alu_sum;
            2'b01:   bus.alu_f = ~bus.alu_b;
            2'b10:   bus.alu_f = bus.alu_a & bus.alu_b;
            default: bus.alu_f = bus.alu_a | bus.alu_b;
        endcase
        bus.alu_ovf = (bus.alu_a[7] == bus.alu_b[7]) && (alu_sum[7] != bus.alu_a[7]);
    end

    int          n_checks = 0;
    int          n_err    = 0;
    logic [7:0]  model_acc;
    logic [8:0]  exp_q [$];
    tcmd_t       pend_q [$];

    function automatic logic [8:0] ref_result(tcmd_t c, logic [7:0] acc_in);
        int          sa;
        int          sb;
        int          ssum;
        logic [7:0]  opa;
        logic [7:0]  r;
        logic        o;
        opa = c.src ? c.a : acc_in;
        o   = 1'b0;
        case (c.op)
            2'b00: begin
                sa   = int'($signed(opa));
                sb   = int'($signed(c.b));
                ssum = sa + sb;
                r    = 8'((int'(opa) + int'(c.b)) % 256);
                o    = (ssum > 127) || (ssum < -128);
            end
            2'b01:   r = ~c.b;
            2'b10:   r = opa & c.b;
            default: r = opa | c.b;
        endcase
        return {o, r};
    endfunction

    task automatic model_accept(tcmd_t c);
        logic [8:0] r;
        r = ref_result(c, model_acc);
        model_acc = r[7:0];
        exp_q.push_back(r);
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(tcmd_t c);
        bus.cmd_op  = c.op;
        bus.cmd_src = c.src;
        bus.cmd_a   = c.a;
        bus.cmd_b   = c.b;
    endtask

    task automatic enq(tcmd_t c);
        drive_cmd(c);
        bus.cmd_valid = 1'b1;
        chk("enq_ready", {31'b0, bus.cmd_ready}, 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        model_accept(c);
    endtask

    task automatic wait_res(input int start, output int lat);
        lat = start;
        while (!bus.res_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic ack(string tag);
        logic [8:0] e;
        chk({tag, "_valid"}, {31'b0, bus.res_valid}, 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, {24'b0, bus.res_data}, {24'b0, e[7:0]});
            chk({tag, "_ovf"}, {31'b0, bus.res_ovf}, {31'b0, e[8]});
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk({tag, "_released"}, {31'b0, bus.res_valid}, 32'd0);
    endtask

    task automatic traffic(int budget, bit rand_ready);
        int   cyc;
        bit   acc_now;
        bit   hs;
        logic [8:0] e;
        cyc = 0;
        while ((pend_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
            if (pend_q.size() > 0) begin
                drive_cmd(pend_q[0]);
                bus.cmd_valid = 1'b1;
            end else begin
                bus.cmd_valid = 1'b0;
            end
            bus.res_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            acc_now = bus.cmd_valid && bus.cmd_ready;
            hs      = bus.res_valid && bus.res_ready;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_result", {31'b0, bus.res_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("trf_data", {24'b0, bus.res_data}, {24'b0, e[7:0]});
                    chk("trf_ovf", {31'b0, bus.res_ovf}, {31'b0, e[8]});
                end
            end
            tick();
            cyc++;
            if (acc_now) model_accept(pend_q.pop_front());
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b0;
        chk("traffic_drained", pend_q.size() + exp_q.size(), 32'd0);
    endtask

    function automatic tcmd_t rand_cmd();
        tcmd_t c;
        c.op  = 2'($urandom_range(0, 3));
        c.src = 1'($urandom_range(0, 1));
        c.a   = 8'($urandom_range(0, 255));
        c.b   = 8'($urandom_range(0, 255));
        return c;
    endfunction

    initial begin
        int   lat;
        int   accepted;
        int   seen;
        bit   acc_now;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_src   = 1'b0;
        bus.cmd_a     = 8'h00;
        bus.cmd_b     = 8'h00;
        bus.res_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        model_acc     = 8'h00;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
        chk("rst_res_valid", {31'b0, bus.res_valid}, 32'd0);
        chk("rst_res_data", {24'b0, bus.res_data}, 32'd0);
        chk("rst_acc", {24'b0, bus.acc}, 32'd0);
        chk("rst_sticky", {31'b0, bus.ovf_sticky}, 32'd0);
        chk("rst_alu", {14'b0, bus.alu_a, bus.alu_b, bus.alu_s}, 32'd0);

        // Simple add, latency of 3 edges from enqueue
        enq('{op: 2'b00, src: 1'b1, a: 8'h07, b: 8'h64});
        wait_res(1, lat);
        chk("add_latency", lat, 32'd3);
        chk("add_data_lit", {24'b0, bus.res_data}, 32'h6B);
        chk("add_acc", {24'b0, bus.acc}, 32'h6B);
        ack("add");

        // Signed overflow, sticky, clear
        enq('{op: 2'b00, src: 1'b1, a: 8'h50, b: 8'h5A});
        wait_res(1, lat);
        chk("ovf_latency", lat, 32'd3);
        chk("ovf_data_lit", {23'b0, bus.res_ovf, bus.res_data}, 32'h1AA);
        chk("ovf_sticky_set", {31'b0, bus.ovf_sticky}, 32'd1);
        ack("ovf");
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("ovf_sticky_clr", {31'b0, bus.ovf_sticky}, 32'd0);

        // Accumulator as operand a
        enq('{op: 2'b10, src: 1'b1, a: 8'h0F, b: 8'hFF});
        wait_res(1, lat);
        ack("and");
        enq('{op: 2'b01, src: 1'b0, a: 8'hEE, b: 8'h5A});
        tick();
        chk("notb_alu_a", {24'b0, bus.alu_a}, 32'h0F);
        chk("notb_alu_bs", {22'b0, bus.alu_b, bus.alu_s}, {22'b0, 8'h5A, 2'b01});
        wait_res(2, lat);
        chk("notb_data_lit", {23'b0, bus.res_ovf, bus.res_data}, 32'h0A5);
        ack("notb");
        enq('{op: 2'b11, src: 1'b0, a: 8'h00, b: 8'h10});
        wait_res(1, lat);
        chk("or_data_lit", {24'b0, bus.res_data}, 32'hB5);
        ack("or");

        // Backpressure: 1 in flight + 4 queued, then full
        for (int i = 0; i < 6; i++) pend_q.push_back(rand_cmd());
        accepted = 0;
        for (int cyc = 0; cyc < 20 && accepted < 5; cyc++) begin
            drive_cmd(pend_q[0]);
            bus.cmd_valid = 1'b1;
            acc_now = bus.cmd_ready;
            tick();
            if (acc_now) begin
                model_accept(pend_q.pop_front());
                accepted++;
            end
        end
        chk("bp_accepted", accepted, 32'd5);
        drive_cmd(pend_q[0]);
        chk("bp_full", {31'b0, bus.cmd_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_still_full", {31'b0, bus.cmd_ready}, 32'd0);
            chk("bp_held_valid", {31'b0, bus.res_valid}, 32'd1);
            chk("bp_stable", {23'b0, bus.res_ovf, bus.res_data}, {23'b0, exp_q[0]});
        end
        traffic(200, 1'b0);

        // Simultaneous sticky set and clear keeps it set
        enq('{op: 2'b00, src: 1'b1, a: 8'h50, b: 8'h5A});
        tick();
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("sticky_set_wins", {31'b0, bus.ovf_sticky}, 32'd1);
        ack("setclr");

        // Reset during EXEC drops the in-flight command
        enq('{op: 2'b00, src: 1'b1, a: 8'h7F, b: 8'h01});
        tick();
        chk("inflight_alu_a", {24'b0, bus.alu_a}, 32'h7F);
        rst = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.res_ready = 1'b1;
        tick();
        rst = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b0;
        exp_q.delete();
        model_acc = 8'h00;
        chk("rexec_res_valid", {31'b0, bus.res_valid}, 32'd0);
        chk("rexec_acc", {24'b0, bus.acc}, 32'd0);
        chk("rexec_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
        chk("rexec_sticky", {31'b0, bus.ovf_sticky}, 32'd0);
        chk("rexec_alu", {14'b0, bus.alu_a, bus.alu_b, bus.alu_s}, 32'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.res_valid) seen++;
        end
        chk("rexec_no_result", seen, 32'd0);

        // Random traffic with random result backpressure
        for (int i = 0; i < 24; i++) pend_q.push_back(rand_cmd());
        traffic(2000, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
